// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE/RUN/HALT sequencer, PC, instruction register and
// a 16-entry branch-target lookup table, with single-bubble branch resolution.
module fetch_unit (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       done_i,
    input  logic       branch_i,
    input  logic       lookup_i,
    input  logic       branch_taken_i,
    input  logic [8:0] imem_data_i,
    input  logic       lut_wr_en_i,
    input  logic [3:0] lut_wr_addr_i,
    input  logic [9:0] lut_wr_data_i,
    output logic [9:0] imem_addr_o,
    output logic [8:0] instr_o,
    output logic       instr_valid_o,
    output logic       running_o,
    output logic       halted_o,
    output logic [15:0] cycle_count_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  pc_q, pc_d;
    logic [9:0]  irpc_q, irpc_d;
    logic [8:0]  instr_q, instr_d;
    logic        vld_q, vld_d;
    logic [15:0] cc_q, cc_d;
    logic [9:0]  lut_q [16];

    logic [9:0]  rel_offset;
    logic [9:0]  target;
    logic        take_branch;
    logic        halt_req;

    // Relative targets are computed from the address the branch was fetched from.
    assign rel_offset  = {{6{instr_q[3]}}, instr_q[3:0]};
    assign target      = lookup_i ? lut_q[instr_q[3:0]] : (irpc_q + rel_offset);
    assign halt_req    = vld_q && done_i;
    assign take_branch = vld_q && branch_i && branch_taken_i;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        irpc_d  = irpc_q;
        instr_d = instr_q;
        vld_d   = vld_q;
        cc_d    = cc_q;
        case (state_q)
            IDLE, HALT: begin
                if (start_i) begin
                    state_d = RUN;
                    pc_d    = '0;
                    cc_d    = '0;
                    vld_d   = 1'b0;
                end
            end
            RUN: begin
                cc_d = (cc_q == 16'hFFFF) ? cc_q : cc_q + 16'd1;
                if (halt_req) begin
                    state_d = HALT;
                    vld_d   = 1'b0;
                end else begin
                    instr_d = imem_data_i;
                    irpc_d  = pc_q;
                    pc_d    = pc_q + 10'd1;
                    vld_d   = 1'b1;
                    // The word fetched alongside a taken branch is squashed.
                    if (take_branch) begin
                        pc_d  = target;
                        vld_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pc_q    <= '0;
            irpc_q  <= '0;
            instr_q <= '0;
            vld_q   <= 1'b0;
            cc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            irpc_q  <= irpc_d;
            instr_q <= instr_d;
            vld_q   <= vld_d;
            cc_q    <= cc_d;
        end
    end

    // Table writes are only accepted while no program is executing.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 16; i++) begin
                lut_q[i] <= '0;
            end
        end else if (lut_wr_en_i && (state_q != RUN)) begin
            lut_q[lut_wr_addr_i] <= lut_wr_data_i;
        end
    end

    assign imem_addr_o   = pc_q;
    assign instr_o       = instr_q;
    assign instr_valid_o = vld_q;
    assign running_o     = (state_q == RUN);
    assign halted_o      = (state_q == HALT);
    assign cycle_count_o = cc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed-vector bench for fetch_unit: a table of per-cycle inputs and expected
// outputs, followed by hand-written reset, LUT-clear and saturation sequences.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, done, branch, lookup, taken;
    logic [8:0]  imem_data;
    logic        lut_we;
    logic [3:0]  lut_wa;
    logic [9:0]  lut_wd;
    logic [9:0]  imem_addr;
    logic [8:0]  instr;
    logic        instr_valid, running, halted;
    logic [15:0] cycle_count;

    logic [8:0]  imem [1024];

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic        st, dn, br, lk, tk, we;
        logic [3:0]  wa;
        logic [9:0]  wd;
        logic        ci;
        logic [9:0]  addr;
        logic [8:0]  instr;
        logic        vld, run, hlt;
        logic [15:0] cc;
    } vec_t;

    vec_t vq[$];

    fetch_unit dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .done_i         (done),
        .branch_i       (branch),
        .lookup_i       (lookup),
        .branch_taken_i (taken),
        .imem_data_i    (imem_data),
        .lut_wr_en_i    (lut_we),
        .lut_wr_addr_i  (lut_wa),
        .lut_wr_data_i  (lut_wd),
        .imem_addr_o    (imem_addr),
        .instr_o        (instr),
        .instr_valid_o  (instr_valid),
        .running_o      (running),
        .halted_o       (halted),
        .cycle_count_o  (cycle_count)
    );

    always #5 clk = ~clk;

    assign imem_data = imem[imem_addr];

    function automatic vec_t mk(input bit st, dn, br, lk, tk, we, input int wa, wd,
                                input bit ci, input int addr, ins, input bit v, r, h,
                                input int cc);
        vec_t t;
        t.st = st; t.dn = dn; t.br = br; t.lk = lk; t.tk = tk; t.we = we;
        t.wa = 4'(wa); t.wd = 10'(wd); t.ci = ci;
        t.addr = 10'(addr); t.instr = 9'(ins);
        t.vld = v; t.run = r; t.hlt = h; t.cc = 16'(cc);
        return t;
    endfunction

    task automatic check(input string name, input vec_t e);
        logic [37:0] act, exp;
        act = {imem_addr, instr, instr_valid, running, halted, cycle_count};
        exp = {e.addr, e.instr, e.vld, e.run, e.hlt, e.cc};
        if (!e.ci) begin
            act[27:19] = '0;
            exp[27:19] = '0;
        end
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got addr=%h instr=%h vld=%b run=%b hlt=%b cc=%h, want addr=%h instr=%h vld=%b run=%b hlt=%b cc=%h",
                     name, imem_addr, instr, instr_valid, running, halted, cycle_count,
                     e.addr, e.instr, e.vld, e.run, e.hlt, e.cc);
        end
    endtask

    task automatic apply(input string name, input vec_t v);
        @(negedge clk);
        start = v.st; done = v.dn; branch = v.br; lookup = v.lk; taken = v.tk;
        lut_we = v.we; lut_wa = v.wa; lut_wd = v.wd;
        @(posedge clk);
        #1;
        check(name, v);
    endtask

    initial begin
        for (int n = 0; n < 1024; n++) begin
            imem[n] = 9'(n) ^ {n[9], 8'h00};
        end
        imem[2] = 9'h1AC;
        imem[3] = 9'h1A5;

        //        st dn br lk tk we wa wd      ci addr   instr  v  r  h  cc
        // Run 1: LUT load in IDLE, sequential fetch, ignored inputs, halt at 7
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 5, 10'h200, 1, 10'h000, 9'h000, 0, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,       0, 10'h000, 9'h000, 0, 1, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,       1, 10'h001, 9'h000, 1, 1, 0, 1));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,       1, 10'h002, 9'h001, 1, 1, 0, 2));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 5, 10'h155, 1, 10'h003, 9'h1AC, 1, 1, 0, 3));
        vq.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0,       1, 10'h004, 9'h1A5, 1, 1, 0, 4));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,       1, 10'h005, 9'h004, 1, 1, 0, 5));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,       1, 10'h006, 9'h005, 1, 1, 0, 6));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,       1, 10'h007, 9'h006, 1, 1, 0, 7));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,       1, 10'h008, 9'h007, 1, 1, 0, 8));
        vq.push_back(mk(0, 1, 1, 0, 1, 0, 0, 0,       1, 10'h008, 9'h007, 0, 0, 1, 9));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,       1, 10'h008, 9'h007, 0, 0, 1, 9));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 6, 10'h3F0, 1, 10'h008, 9'h007, 0, 0, 1, 9));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,       0, 10'h000, 9'h000, 0, 1, 0, 0));
        // Run 2: relative branch -4 from 2, wrap, lookup branches via LUT[5] and LUT[6]
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,       1, 10'h001, 9'h000, 1, 1, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,       1, 10'h002, 9'h001, 1, 1, 0, 2));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,       1, 10'h003, 9'h1AC, 1, 1, 0, 3));
        vq.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0,       1, 10'h3FE, 9'h1A5, 0, 1, 0, 4));
        vq.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0,       1, 10'h3FF, 9'h0FE, 1, 1, 0, 5));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,       1, 10'h000, 9'h0FF, 1, 1, 0, 6));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,       1, 10'h001, 9'h000, 1, 1, 0, 7));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,       1, 10'h002, 9'h001, 1, 1, 0, 8));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,       1, 10'h003, 9'h1AC, 1, 1, 0, 9));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,       1, 10'h004, 9'h1A5, 1, 1, 0, 10));
        vq.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0,       1, 10'h200, 9'h004, 0, 1, 0, 11));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,       1, 10'h201, 9'h100, 1, 1, 0, 12));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,       1, 10'h202, 9'h101, 1, 1, 0, 13));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,       1, 10'h203, 9'h102, 1, 1, 0, 14));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,       1, 10'h204, 9'h103, 1, 1, 0, 15));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,       1, 10'h205, 9'h104, 1, 1, 0, 16));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,       1, 10'h206, 9'h105, 1, 1, 0, 17));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,       1, 10'h207, 9'h106, 1, 1, 0, 18));
        vq.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0,       1, 10'h3F0, 9'h107, 0, 1, 0, 19));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,       1, 10'h3F1, 9'h0F0, 1, 1, 0, 20));

        start = 0; done = 0; branch = 0; lookup = 0; taken = 0;
        lut_we = 0; lut_wa = 0; lut_wd = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            apply($sformatf("vec%0d", i), vq[i]);
        end

        // Asynchronous reset between edges in the middle of a run
        @(negedge clk);
        done = 0; branch = 0; lookup = 0; taken = 0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("idle_after_reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));

        // Reset cleared the table: LUT[5] now targets address 0
        apply("clr_start", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 10'h000, 9'h000, 0, 1, 0, 0));
        apply("clr_f1",    mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 10'h001, 9'h000, 1, 1, 0, 1));
        apply("clr_f2",    mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 10'h002, 9'h001, 1, 1, 0, 2));
        apply("clr_f3",    mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 10'h003, 9'h1AC, 1, 1, 0, 3));
        apply("clr_f4",    mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 10'h004, 9'h1A5, 1, 1, 0, 4));
        apply("clr_br",    mk(0, 0, 1, 1, 1, 0, 0, 0, 1, 10'h000, 9'h004, 0, 1, 0, 5));

        // Cycle counter saturates instead of wrapping
        @(negedge clk);
        branch = 0; lookup = 0; taken = 0;
        repeat (65535) @(posedge clk);
        #1;
        n_vec++;
        if (cycle_count !== 16'hFFFF || running !== 1'b1) begin
            n_fail++;
            $display("FAIL cc_saturate: got cc=%h run=%b, want cc=ffff run=1",
                     cycle_count, running);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Clk  in  1  single clock; all state updates on rising edge.
REQ-002 Reset  in  1  asynchronous, active-low reset.
REQ-003 Start  in  1  level, sampled each edge; begins program from PC 0.
REQ-004 Done  in  1  halt decode from Control for the instruction in Instr.
REQ-005 Branch  in  1  branch decode from Control for Instr.
REQ-006 Lookup  in  1  1: target from lookup table; 0: PC-relative target.
REQ-007 BranchTaken  in  1  branch condition from datapath, same cycle as Branch.
REQ-008 ImemData  in  9  combinational instruction-memory read data at ImemAddr.
REQ-009 LutWrEn, LutWrAddr, LutWrData  in  1/4/10  lookup-table write port.
REQ-010 ImemAddr  out  10  current PC.
REQ-011 Instr  out  9  instruction register {opcode[8:5], identifier[4], operand[3:0]} feeding Control.
REQ-012 InstrValid  out  1  Instr is live; Control outputs are ignored when 0.
REQ-013 Running, Halted  out  1/1  FSM status.
REQ-014 CycleCount  out  16  count of RUN cycles in the current program.

Function
REQ-015 FSM states: IDLE, RUN, HALT; Running=1 only in RUN, Halted=1 only in HALT.
REQ-016 IDLE: Start=1 -> RUN next edge; PC<=0, CycleCount<=0, InstrValid<=0.
REQ-017 RUN, default cycle: Instr<=ImemData, IrPc<=PC, InstrValid<=1, PC<=PC+1 mod 1024 (1023 wraps to 0).
REQ-018 RUN, InstrValid=1 and Done=1: -> HALT; InstrValid<=0; PC and Instr hold.
REQ-019 RUN, InstrValid=1, Branch=1, BranchTaken=1, Done=0: PC<=target; InstrValid<=0 (squash the fetch made this cycle); Instr still loads ImemData but is marked invalid.
REQ-020 Target: Lookup=1 -> LUT[Instr[3:0]]; Lookup=0 -> IrPc + sign-extended Instr[3:0] (range -8..+7), mod 1024.
REQ-021 Branch=1 with BranchTaken=0: default cycle (REQ-017).
REQ-022 Done/Branch/BranchTaken ignored when InstrValid=0 or state is not RUN.
REQ-023 Priority when simultaneous: Done over Branch.
REQ-024 Branch resolution latency: target address appears on ImemAddr the cycle after the branch is in Instr; one bubble (InstrValid=0) follows every taken branch.
REQ-025 Start=1 in RUN ignored; Start=1 in HALT -> RUN with PC<=0, CycleCount<=0, InstrValid<=0.
REQ-026 CycleCount increments by 1 each RUN cycle, saturating at 16'hFFFF; holds in IDLE/HALT.
REQ-027 LUT: 16 x 10-bit, written on edge when LutWrEn=1 and state is IDLE or HALT; writes in RUN dropped.
REQ-028 LUT write and a lookup branch to the same entry cannot coincide (REQ-027); no bypass required.

Reset
REQ-029 Reset=0 asynchronously forces: state IDLE, PC=0, Instr=0, IrPc=0, InstrValid=0, CycleCount=0, all LUT entries 0; Running=0, Halted=0.
REQ-030 Reset asserted mid-RUN aborts immediately; any in-progress branch or halt is discarded.
REQ-031 After Reset deasserts, the block stays in IDLE until Start=1 is sampled.

Verification
REQ-032 Sequential fetch: Start pulse, imem[n]=n, no Branch/Done -> ImemAddr 0,1,2,...; Instr=ImemData of previous cycle, InstrValid=1 from the second RUN cycle.
REQ-033 Lookup branch: LUT[5]=10'h200 written in IDLE; branch at addr 3 with operand 5, Lookup=1, BranchTaken=1 -> ImemAddr=0x200 next cycle, one InstrValid=0 bubble, then Instr=imem[0x200].
REQ-034 Relative branch and wrap: branch at IrPc=2, operand 4'hC (-4), Lookup=0, taken -> PC=1022; sequential run continues 1023, 0.
REQ-035 Halt: Done at addr 7 together with Branch taken -> HALT, Halted=1, ImemAddr holds 8, CycleCount frozen; Start -> RUN from PC 0 with CycleCount=0.
REQ-036 Not-taken and ignored inputs: Branch=1, BranchTaken=0 -> PC+1; LutWrEn in RUN leaves LUT unchanged (read back via later lookup branch); Start in RUN has no effect.
REQ-037 Async reset: Reset=0 between clock edges mid-RUN -> all outputs at REQ-029 values before next edge; no Start -> remains IDLE.
